alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter and sequencer that shares the core's single combinational ALU between two requesters, e.g. the execute stage and a secondary address/compare unit. Each requester issues an operation over a valid/ready handshake. The block grants one requester at a time in round-robin order, drives the ALU from registered operands, captures the result and zero flag, and returns them on a per-port valid/ready response channel. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

## Interface
Parameters:
- XLEN, 32, operand/result width; must match ALU width.

Ports (i = 0, 1 for each per-port group):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req{i}_valid  in  1  requester i presents an operation
- req{i}_ready  out  1  block accepts requester i's operation this cycle
- req{i}_src1  in  XLEN  operand 1
- req{i}_src2  in  XLEN  operand 2
- req{i}_ctrl  in  4  ALU_Ctrl encoding
- rsp{i}_valid  out  1  result for requester i available
- rsp{i}_ready  in  1  requester i consumes the result
- rsp{i}_result  out  XLEN  captured ALU_result
- rsp{i}_zero  out  1  captured zero flag
- rsp{i}_err  out  1  ctrl was not a legal encoding
- alu_src1  out  XLEN  to ALU
- alu_src2  out  XLEN  to ALU
- ALU_Ctrl  out  4  to ALU
- ALU_result  in  XLEN  from ALU
- zero  in  1  from ALU

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: pick a requester among those asserting valid.
  - Only one valid: that one.
  - Both valid: the one named by the priority pointer `prio` (reset 0).
  - req_ready is asserted combinationally only for the picked port, only in IDLE.
  - On the handshake: latch src1/src2/ctrl into operand registers, record the grant index, go to EXEC.
- EXEC: the ALU is driven from the operand registers.
  - Capture ALU_result into the result register and zero into the zero register; go to RESP.
  - If the latched ctrl is not in {0000, 1000, 0110, 0111, 0100, 0010, 0011, 0001, 0101, 1101}: result register loads 0, err loads 1, zero is still captured. Otherwise err loads 0.
- RESP: rsp_valid is asserted for the granted port only; result/zero/err are driven to that port.
  - The other port's rsp outputs are 0.
  - Hold until rsp_ready is high for the granted port, then set prio to the other port and go to IDLE.
- alu_src1/alu_src2/ALU_Ctrl always reflect the operand registers and stay stable outside EXEC.
- req_valid deasserting without a handshake is permitted and has no effect.
- Requester inputs are ignored outside IDLE; the ungranted port sees ready = 0.

## Timing
- Reset values:
  - All ready/valid outputs 0.
  - Operand registers, result, zero, err and prio all 0.
  - ALU drive outputs therefore 0.
- Reset asserted mid-operation: FSM returns to IDLE immediately and the in-flight operation is discarded. No response is produced.
- Latency: request handshake in cycle T; rsp_valid high from cycle T+2.
- Minimum spacing between accepts is 3 cycles, reached when rsp_ready is held high.
- Results wider than XLEN are not possible: ALU width rules apply unchanged, i.e. shift amounts are whatever the ALU consumes.
- Simultaneous events:
  - Both req_valid high in IDLE: prio decides.
  - A new request arriving during EXEC/RESP waits; it is not lost as long as the requester holds valid.

## Structure
- Shared package alu_pkg:
  - localparams for the 10 legal ALU_Ctrl encodings;
  - typedef enum for FSM states (IDLE/EXEC/RESP);
  - a function `alu_ctrl_legal(ctrl)`.
- One sub-module: rr_pick2, a combinational 2-way round-robin picker.
  - Inputs: valid[1:0], prio.
  - Outputs: grant one-hot, grant_idx.

## Test plan
- Single op: req0 ADD src1=5, src2=7 -> rsp0_valid at T+2 with result=12, zero=0, err=0; rsp1_valid stays 0.
- Contention: req0 SUB 9-9 and req1 SLTU 1<2 both valid at reset-exit -> port 0 served first (result=0, zero=1), then port 1 (result=1).
- Alternation: port 0 and port 1 each hold valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; accepts 3 cycles apart.
- Backpressure: rsp0_ready held 0 for 5 cycles -> rsp0_valid and rsp0_result stay constant, req1_ready stays 0 throughout.
- Illegal ctrl: req1 ctrl=1111 -> rsp1_result=0, rsp1_err=1.
- Reset mid-op: assert reset in EXEC -> all outputs 0 next edge, no rsp_valid afterwards, then a fresh req0 SRA 0x80000000 by 4 -> result 0xF8000000.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU_Ctrl encodings, sequencer states and legality check shared by the ALU arbiter

package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
        logic legal;
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR,
            ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - requester/response channels and ALU drive bundle for alu_share_arb

interface alu_share_arb_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_src1;
    logic [XLEN-1:0] req0_src2;
    logic [3:0]      req0_ctrl;
    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_src1;
    logic [XLEN-1:0] req1_src2;
    logic [3:0]      req1_ctrl;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [XLEN-1:0] rsp0_result;
    logic            rsp0_zero;
    logic            rsp0_err;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp1_result;
    logic            rsp1_zero;
    logic            rsp1_err;

    logic [XLEN-1:0] alu_src1;
    logic [XLEN-1:0] alu_src2;
    logic [3:0]      ALU_Ctrl;
    logic [XLEN-1:0] ALU_result;
    logic            zero;

    // Requesters plus the ALU instance on one side.
    modport master (
        output req0_valid, req0_src1, req0_src2, req0_ctrl,
        output req1_valid, req1_src1, req1_src2, req1_ctrl,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
        output rsp0_ready, rsp1_ready,
        input  alu_src1, alu_src2, ALU_Ctrl,
        output ALU_result, zero
    );

    modport slave (
        input  req0_valid, req0_src1, req0_src2, req0_ctrl,
        input  req1_valid, req1_src1, req1_src2, req1_ctrl,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
        input  rsp0_ready, rsp1_ready,
        output alu_src1, alu_src2, ALU_Ctrl,
        input  ALU_result, zero
    );
endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker

module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       grant_idx
);
    always_comb begin
        grant_idx = (valid == 2'b11) ? prio : valid[1];
        grant     = 2'b00;
        if (|valid) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one combinational ALU between two requesters

module alu_share_arb
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            reset,
    alu_share_arb_if.slave bus
);
    arb_state_t      state, state_nxt;
    logic            prio;
    logic            gidx;
    logic [1:0]      grant;
    logic            pick_idx;
    logic            accept;
    logic            done;
    logic [XLEN-1:0] op_src1;
    logic [XLEN-1:0] op_src2;
    logic [3:0]      op_ctrl;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic            err_q;

    rr_pick2 u_pick (
        .valid     ({bus.req1_valid, bus.req0_valid}),
        .prio      (prio),
        .grant     (grant),
        .grant_idx (pick_idx)
    );

    assign bus.alu_src1 = op_src1;
    assign bus.alu_src2 = op_src2;
    assign bus.ALU_Ctrl = op_ctrl;

    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        done            = 1'b0;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.rsp0_valid  = 1'b0;
        bus.rsp0_result = '0;
        bus.rsp0_zero   = 1'b0;
        bus.rsp0_err    = 1'b0;
        bus.rsp1_valid  = 1'b0;
        bus.rsp1_result = '0;
        bus.rsp1_zero   = 1'b0;
        bus.rsp1_err    = 1'b0;
        case (state)
            IDLE: begin
                // Ready is combinational from valid, so hold it off while reset is applied.
                if (!reset) begin
                    bus.req0_ready = grant[0];
                    bus.req1_ready = grant[1];
                    if (|grant) begin
                        accept    = 1'b1;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (gidx == 1'b0) begin
                    bus.rsp0_valid  = 1'b1;
                    bus.rsp0_result = res_q;
                    bus.rsp0_zero   = zero_q;
                    bus.rsp0_err    = err_q;
                    done            = bus.rsp0_ready;
                end else begin
                    bus.rsp1_valid  = 1'b1;
                    bus.rsp1_result = res_q;
                    bus.rsp1_zero   = zero_q;
                    bus.rsp1_err    = err_q;
                    done            = bus.rsp1_ready;
                end
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio    <= 1'b0;
            gidx    <= 1'b0;
            op_src1 <= '0;
            op_src2 <= '0;
            op_ctrl <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                gidx    <= pick_idx;
                op_src1 <= pick_idx ? bus.req1_src1 : bus.req0_src1;
                op_src2 <= pick_idx ? bus.req1_src2 : bus.req0_src2;
                op_ctrl <= pick_idx ? bus.req1_ctrl : bus.req0_ctrl;
            end
            if (state == EXEC) begin
                res_q  <= alu_ctrl_legal(op_ctrl) ? bus.ALU_result : '0;
                zero_q <= bus.zero;
                err_q  <= !alu_ctrl_legal(op_ctrl);
            end
            if (done) begin
                prio <= ~gidx;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb

module tb_alu_share_arb;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;

    alu_share_arb_if #(.XLEN(XLEN)) bus ();

    alu_share_arb #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [31:0] r;
        case (c)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b0100: r = a ^ b;
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0001: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            default: r = 32'hDEADBEEF;
        endcase
        return r;
    endfunction

    function automatic logic is_legal(input logic [3:0] c);
        return c inside {4'b0000, 4'b1000, 4'b0110, 4'b0111, 4'b0100,
                         4'b0010, 4'b0011, 4'b0001, 4'b0101, 4'b1101};
    endfunction

    // Stand-in for the core's combinational ALU.
    always_comb begin
        logic [31:0] r;
        r = alu_model(bus.alu_src1, bus.alu_src2, bus.ALU_Ctrl);
        bus.ALU_result = r;
        bus.zero       = (r == 32'd0);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] c);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_src1 = s1; bus.req0_src2 = s2; bus.req0_ctrl = c;
        end else begin
            bus.req1_valid = v; bus.req1_src1 = s1; bus.req1_src2 = s2; bus.req1_ctrl = c;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) bus.rsp0_ready = v;
        else        bus.rsp1_ready = v;
    endtask

    function automatic logic get_ready(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction
    function automatic logic get_rsp_valid(input int p);
        return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction
    function automatic logic get_rsp_ready(input int p);
        return (p == 0) ? bus.rsp0_ready : bus.rsp1_ready;
    endfunction
    function automatic logic [31:0] get_result(input int p);
        return (p == 0) ? bus.rsp0_result : bus.rsp1_result;
    endfunction
    function automatic logic get_zero(input int p);
        return (p == 0) ? bus.rsp0_zero : bus.rsp1_zero;
    endfunction
    function automatic logic get_err(input int p);
        return (p == 0) ? bus.rsp0_err : bus.rsp1_err;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  c;
        logic [31:0] res;
        logic        z;
        logic        e;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        set_req(v.port, 1'b1, v.s1, v.s2, v.c);
        #1;
        chk1({tag, "_ready"}, get_ready(v.port), 1'b1);
        chk1({tag, "_other_ready"}, get_ready(1 - v.port), 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_req(v.port, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        chk1({tag, "_exec_rsp_valid"}, get_rsp_valid(v.port), 1'b0);
        chk32({tag, "_alu_src1"}, bus.alu_src1, v.s1);
        chk32({tag, "_alu_src2"}, bus.alu_src2, v.s2);
        chk32({tag, "_alu_ctrl"}, {28'd0, bus.ALU_Ctrl}, {28'd0, v.c});
        @(negedge clk);
        #1;
        chk1({tag, "_rsp_valid"}, get_rsp_valid(v.port), 1'b1);
        chk1({tag, "_other_rsp_valid"}, get_rsp_valid(1 - v.port), 1'b0);
        chk32({tag, "_result"}, get_result(v.port), v.res);
        chk1({tag, "_zero"}, get_zero(v.port), v.z);
        chk1({tag, "_err"}, get_err(v.port), v.e);
        set_rsp_ready(v.port, 1'b1);
        @(posedge clk);
        #1;
        set_rsp_ready(v.port, 1'b0);
    endtask

    // Reference model state for the randomized phase: one op in flight at most.
    logic        pv[2];
    logic [31:0] ps1[2];
    logic [31:0] ps2[2];
    logic [3:0]  pc[2];
    logic        busy;
    logic        last_served;
    int          op_port;
    int          acc_cycle;
    int          cyc;
    logic [31:0] os1, os2, exp_res;
    logic [3:0]  oc;
    logic        exp_zero, exp_err;

    task automatic rand_cycle(input bit gen);
        logic [1:0] v;
        logic [1:0] exp_rdy;
        logic       pick;
        logic       rsp_done;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (gen) begin
                if (!pv[p] && $urandom_range(0, 2) == 0) begin
                    pv[p]  = 1'b1;
                    ps1[p] = $urandom;
                    ps2[p] = ($urandom_range(0, 3) == 0) ? ps1[p] : $urandom;
                    pc[p]  = 4'($urandom_range(0, 15));
                end else if (pv[p] && $urandom_range(0, 9) == 0) begin
                    pv[p] = 1'b0;
                end
            end
            set_req(p, pv[p], ps1[p], ps2[p], pc[p]);
            set_rsp_ready(p, gen ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        #1;
        v        = {pv[1], pv[0]};
        exp_rdy  = 2'b00;
        pick     = 1'b0;
        rsp_done = 1'b0;
        if (!busy && v != 2'b00) begin
            pick          = (v == 2'b11) ? ~last_served : v[1];
            exp_rdy[pick] = 1'b1;
        end
        chk1("rand_req0_ready", bus.req0_ready, exp_rdy[0]);
        chk1("rand_req1_ready", bus.req1_ready, exp_rdy[1]);
        if (busy) begin
            chk32("rand_alu_src1", bus.alu_src1, os1);
            chk32("rand_alu_ctrl", {28'd0, bus.ALU_Ctrl}, {28'd0, oc});
            if (cyc - acc_cycle >= 2) begin
                chk1("rand_rsp_valid", get_rsp_valid(op_port), 1'b1);
                chk1("rand_other_rsp_valid", get_rsp_valid(1 - op_port), 1'b0);
                chk32("rand_result", get_result(op_port), exp_res);
                chk1("rand_zero", get_zero(op_port), exp_zero);
                chk1("rand_err", get_err(op_port), exp_err);
                rsp_done = get_rsp_ready(op_port);
            end else begin
                chk1("rand_early_rsp0_valid", bus.rsp0_valid, 1'b0);
                chk1("rand_early_rsp1_valid", bus.rsp1_valid, 1'b0);
            end
        end else begin
            chk1("rand_idle_rsp0_valid", bus.rsp0_valid, 1'b0);
            chk1("rand_idle_rsp1_valid", bus.rsp1_valid, 1'b0);
        end
        if (rsp_done) begin
            busy        = 1'b0;
            last_served = op_port[0];
        end
        if (exp_rdy != 2'b00) begin
            busy      = 1'b1;
            op_port   = int'(pick);
            acc_cycle = cyc;
            os1       = ps1[pick];
            os2       = ps2[pick];
            oc        = pc[pick];
            exp_res   = is_legal(oc) ? alu_model(os1, os2, oc) : 32'd0;
            exp_zero  = (alu_model(os1, os2, oc) == 32'd0);
            exp_err   = !is_legal(oc);
            pv[pick]  = 1'b0;
        end
        @(posedge clk);
        cyc++;
    endtask

    vec_t vecs[14];
    int   gports[$];
    int   gcycles[$];

    initial begin
        vecs[0]  = '{0, 32'd5,          32'd7,          4'b0000, 32'd12,         1'b0, 1'b0};
        vecs[1]  = '{1, 32'd9,          32'd9,          4'b1000, 32'd0,          1'b1, 1'b0};
        vecs[2]  = '{1, 32'd1,          32'd2,          4'b0011, 32'd1,          1'b0, 1'b0};
        vecs[3]  = '{1, 32'd3,          32'd4,          4'b1111, 32'd0,          1'b0, 1'b1};
        vecs[4]  = '{0, 32'h80000000,   32'd4,          4'b1101, 32'hF8000000,   1'b0, 1'b0};
        vecs[5]  = '{0, 32'hFFFFFFFF,   32'd1,          4'b0010, 32'd1,          1'b0, 1'b0};
        vecs[6]  = '{1, 32'hFFFFFFFF,   32'd1,          4'b0011, 32'd0,          1'b1, 1'b0};
        vecs[7]  = '{0, 32'd1,          32'd31,         4'b0001, 32'h80000000,   1'b0, 1'b0};
        vecs[8]  = '{1, 32'h80000000,   32'd36,         4'b0101, 32'h08000000,   1'b0, 1'b0};
        vecs[9]  = '{0, 32'h00005A5A,   32'h00005A5A,   4'b0100, 32'd0,          1'b1, 1'b0};
        vecs[10] = '{1, 32'h000000F0,   32'h0000000F,   4'b0110, 32'h000000FF,   1'b0, 1'b0};
        vecs[11] = '{0, 32'h0000FF00,   32'h00000FF0,   4'b0111, 32'h00000F00,   1'b0, 1'b0};
        vecs[12] = '{0, 32'd6,          32'd2,          4'b1001, 32'd0,          1'b0, 1'b1};
        vecs[13] = '{1, 32'd0,          32'd1,          4'b1000, 32'hFFFFFFFF,   1'b0, 1'b0};

        // Reset state, with both requesters already presenting ops.
        reset = 1'b1;
        set_req(0, 1'b1, 32'd9, 32'd9, 4'b1000);
        set_req(1, 1'b1, 32'd1, 32'd2, 4'b0011);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_req0_ready", bus.req0_ready, 1'b0);
        chk1("rst_req1_ready", bus.req1_ready, 1'b0);
        chk1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk32("rst_alu_src1", bus.alu_src1, 32'd0);
        chk32("rst_alu_src2", bus.alu_src2, 32'd0);
        chk32("rst_alu_ctrl", {28'd0, bus.ALU_Ctrl}, 32'd0);

        // Contention at reset exit: port 0 first, then port 1.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("cont_req0_ready", bus.req0_ready, 1'b1);
        chk1("cont_req1_ready", bus.req1_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        chk1("cont_exec_req1_ready", bus.req1_ready, 1'b0);
        @(negedge clk);
        #1;
        chk1("cont_rsp0_valid", bus.rsp0_valid, 1'b1);
        chk1("cont_rsp1_valid_idle", bus.rsp1_valid, 1'b0);
        chk32("cont_rsp0_result", bus.rsp0_result, 32'd0);
        chk1("cont_rsp0_zero", bus.rsp0_zero, 1'b1);
        set_rsp_ready(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rsp_ready(0, 1'b0);
        #1;
        chk1("cont_second_req1_ready", bus.req1_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        chk1("cont_rsp1_valid", bus.rsp1_valid, 1'b1);
        chk32("cont_rsp1_result", bus.rsp1_result, 32'd1);
        chk1("cont_rsp1_zero", bus.rsp1_zero, 1'b0);
        set_rsp_ready(1, 1'b1);
        @(posedge clk);
        #1;
        set_rsp_ready(1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Alternation with both ports saturated and responses always consumed.
        do_reset();
        set_req(0, 1'b1, 32'd10, 32'd20, 4'b0000);
        set_req(1, 1'b1, 32'd30, 32'd40, 4'b0000);
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);
        for (int i = 0; i < 13; i++) begin
            #1;
            if (bus.req0_ready && bus.req0_valid) begin gports.push_back(0); gcycles.push_back(i); end
            if (bus.req1_ready && bus.req1_valid) begin gports.push_back(1); gcycles.push_back(i); end
            @(negedge clk);
        end
        chk32("alt_accept_count", gports.size(), 32'd5);
        if (gports.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk32($sformatf("alt_grant%0d", i), gports[i], i % 2);
                if (i > 0) chk32($sformatf("alt_gap%0d", i), gcycles[i] - gcycles[i-1], 32'd3);
            end
        end

        // Backpressure on port 0 while port 1 waits.
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'd100, 32'd23, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b1, 32'h0F, 32'hF0, 4'b0110);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1($sformatf("bp_rsp0_valid%0d", i), bus.rsp0_valid, 1'b1);
            chk32($sformatf("bp_rsp0_result%0d", i), bus.rsp0_result, 32'd123);
            chk1($sformatf("bp_req1_ready%0d", i), bus.req1_ready, 1'b0);
            @(negedge clk);
        end
        set_rsp_ready(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rsp_ready(0, 1'b0);
        #1;
        chk1("bp_req1_ready_after", bus.req1_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        chk1("bp_rsp1_valid", bus.rsp1_valid, 1'b1);
        chk32("bp_rsp1_result", bus.rsp1_result, 32'hFF);
        set_rsp_ready(1, 1'b1);
        @(posedge clk);
        #1;
        set_rsp_ready(1, 1'b0);

        // Reset during EXEC discards the op.
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'd5, 32'd7, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_rsp_ready(0, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rmid_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk1("rmid_req0_ready", bus.req0_ready, 1'b0);
        chk32("rmid_alu_src1", bus.alu_src1, 32'd0);
        chk32("rmid_alu_src2", bus.alu_src2, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("rmid_after_rsp0_%0d", i), bus.rsp0_valid, 1'b0);
            chk1($sformatf("rmid_after_rsp1_%0d", i), bus.rsp1_valid, 1'b0);
        end
        set_rsp_ready(0, 1'b0);
        run_vec('{0, 32'h80000000, 32'd4, 4'b1101, 32'hF8000000, 1'b0, 1'b0}, "rmid_sra");

        // Randomized traffic against the reference model.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; ps1[p] = '0; ps2[p] = '0; pc[p] = '0;
        end
        busy        = 1'b0;
        last_served = 1'b1;
        op_port     = 0;
        acc_cycle   = 0;
        cyc         = 0;
        repeat (400) rand_cycle(1'b1);
        for (int i = 0; i < 40; i++) begin
            if (busy || pv[0] || pv[1]) rand_cycle(1'b0);
        end
        chk1("rand_drained", busy | pv[0] | pv[1], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
